// File: rtl/ram_cmd_ctrl.sv
// ram_cmd_ctrl: debounced push-button to RAM write/read command stage (one access per press).
// Define AUTOINC_EN to take addr_o from an internal auto-incrementing pointer instead of sw_addr_i.
module ram_cmd_ctrl #(
  parameter int N = 4,
  parameter int M = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         btn_wr_i,
  input  logic         btn_rd_i,
  input  logic [N-1:0] sw_addr_i,
  input  logic [M-1:0] sw_data_i,
  output logic [N-1:0] addr_o,
  output logic [M-1:0] dato_write_o,
  output logic         wren_o,
  output logic         rden_o,
  output logic         busy_o
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
  localparam logic [5:0] IDLE    = 6'b000001;
  localparam logic [5:0] DEB_WR  = 6'b000010;
  localparam logic [5:0] DEB_RD  = 6'b000100;
  localparam logic [5:0] WRITE   = 6'b001000;
  localparam logic [5:0] READ    = 6'b010000;
  localparam logic [5:0] RELEASE = 6'b100000;
  logic [1:0] wr_sync, rd_sync;
  logic wr_s, rd_s;
  logic [5:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] addr;
  logic [M-1:0] data;
  assign wr_s = wr_sync[1];
  assign rd_s = rd_sync[1];
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = wr_s ? DEB_WR : rd_s ? DEB_RD : IDLE;
      DEB_WR:  state_n = !wr_s ? IDLE : (cnt == CMAX) ? WRITE : DEB_WR;
      DEB_RD:  state_n = !rd_s ? IDLE : (cnt == CMAX) ? READ : DEB_RD;
      WRITE:   state_n = RELEASE;
      READ:    state_n = RELEASE;
      RELEASE: state_n = (!wr_s && !rd_s && cnt == CMAX) ? IDLE : RELEASE;
      default: state_n = IDLE;
    endcase
  end
  // in RELEASE any high sample restarts the quiet-time count
  always_comb begin
    cnt_n = (cnt == CMAX) ? cnt : cnt + 1'b1;
    if (state_n != state || (state == RELEASE && (wr_s || rd_s))) cnt_n = '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_sync <= '0;
      rd_sync <= '0;
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      data    <= '0;
    end else begin
      wr_sync <= {wr_sync[0], btn_wr_i};
      rd_sync <= {rd_sync[0], btn_rd_i};
      state   <= state_n;
      cnt     <= cnt_n;
`ifdef AUTOINC_EN
      if (state == WRITE || state == READ) addr <= addr + 1'b1;
`else
      if (state_n == WRITE || state_n == READ) addr <= sw_addr_i;
`endif
      if (state_n == WRITE) data <= sw_data_i;
    end
  end
`ifdef AUTOINC_EN
  logic unused_sw_addr;
  assign unused_sw_addr = ^sw_addr_i;
`endif
  assign addr_o       = addr;
  assign dato_write_o = data;
  assign wren_o       = state[3];
  assign rden_o       = state[4];
  assign busy_o       = ~state[0];
endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// tb_ram_cmd_ctrl: directed bench with strobe scoreboard for ram_cmd_ctrl (DB_CYCLES=8).
module tb_ram_cmd_ctrl;
  typedef struct {
    logic       wr;
    logic [3:0] a;
    logic [3:0] d;
  } exp_t;
  logic clk_i = 0, rst_i = 1, btn_wr_i = 0, btn_rd_i = 0;
  logic [3:0] sw_addr_i = 0, sw_data_i = 0;
  logic [3:0] addr_o, dato_write_o;
  logic wren_o, rden_o, busy_o;
  int total = 0, bad = 0;
  exp_t q[$];
  logic [3:0] last_d = 0;
`ifdef AUTOINC_EN
  logic [3:0] ptr = 0;
`endif

  ram_cmd_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_wr_i(btn_wr_i), .btn_rd_i(btn_rd_i),
    .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i), .addr_o(addr_o),
    .dato_write_o(dato_write_o), .wren_o(wren_o), .rden_o(rden_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic wr, input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    e.wr = wr;
`ifdef AUTOINC_EN
    e.a = ptr;
    ptr = ptr + 1'b1;
`else
    e.a = a;
`endif
    if (wr) last_d = d;
    e.d = last_d;
    q.push_back(e);
  endtask

  task automatic model_reset();
    last_d = 0;
`ifdef AUTOINC_EN
    ptr = 0;
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    chk(tag, busy_o, 0);
  endtask

  task automatic op(input logic wr, input logic [3:0] a, input logic [3:0] d);
    sw_addr_i = a;
    sw_data_i = d;
    push(wr, a, d);
    if (wr) btn_wr_i = 1; else btn_rd_i = 1;
    repeat (14) tick();
    btn_wr_i = 0;
    btn_rd_i = 0;
    wait_idle("op_idle");
    chk("op_strobe_seen", q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_data"}, dato_write_o, 0);
    chk({tag, "_wren"}, wren_o, 0);
    chk({tag, "_rden"}, rden_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  // scoreboard: every strobe must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (!rst_i && (wren_o || rden_o)) begin
      total++;
      assert (!(wren_o && rden_o)) else begin
        bad++;
        $error("FAIL excl wren=%0b rden=%0b want not both", wren_o, rden_o);
      end
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_strobe wren=%0b rden=%0b addr=%0h want none", wren_o, rden_o, addr_o);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        assert ({wren_o, rden_o, addr_o, dato_write_o} === {e.wr, !e.wr, e.a, e.d}) else begin
          bad++;
          $error("FAIL strobe got wr=%0b rd=%0b a=%0h d=%0h want wr=%0b a=%0h d=%0h",
                 wren_o, rden_o, addr_o, dato_write_o, e.wr, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_busy;
    // 1: reset with both buttons pressed, then a clean write after release
    btn_wr_i = 1;
    btn_rd_i = 1;
    sw_addr_i = 4'h3;
    sw_data_i = 4'hC;
    repeat (3) tick();
    chk_zero("t1_rst");
    btn_rd_i = 0;
    rst_i = 0;
    push(1, 4'h3, 4'hC);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("t1_wren", wren_o, k == 11);
    end
    btn_wr_i = 0;
    wait_idle("t1_idle");
    chk("t1_seen", q.size(), 0);
    // 2: bouncing write button never strobes
    for (int b = 0; b < 5; b++) begin
      seen_busy = 0;
      btn_wr_i = 1;
      repeat (3) begin tick(); seen_busy |= busy_o; end
      btn_wr_i = 0;
      repeat (5) begin tick(); seen_busy |= busy_o; end
      chk("t2_busy_pulsed", seen_busy, 1);
      chk("t2_idle", busy_o, 0);
    end
    // 3: long hold gives exactly one write, busy drops after release quiet time
    sw_addr_i = 4'h5;
    sw_data_i = 4'hA;
    push(1, 4'h5, 4'hA);
    btn_wr_i = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("t3_wren", wren_o, k == 11);
    end
    btn_wr_i = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("t3_busy", busy_o, j < 10);
    end
    chk("t3_seen", q.size(), 0);
    // 4: simultaneous press: write wins, no read until pressed again
    sw_addr_i = 4'h9;
    sw_data_i = 4'h6;
    push(1, 4'h9, 4'h6);
    btn_wr_i = 1;
    btn_rd_i = 1;
    repeat (25) tick();
    btn_wr_i = 0;
    btn_rd_i = 0;
    wait_idle("t4_idle");
    chk("t4_seen", q.size(), 0);
    op(0, 4'h2, 4'hF);
    // 5: reset during DEB_RD and during RELEASE aborts silently
    sw_addr_i = 4'h7;
    btn_rd_i = 1;
    repeat (5) tick();
    chk("t5_deb_busy", busy_o, 1);
    rst_i = 1;
    #1;
    chk_zero("t5_rst_deb");
    model_reset();
    btn_rd_i = 0;
    tick();
    rst_i = 0;
    repeat (20) tick();
    chk("t5_quiet1", busy_o, 0);
    sw_addr_i = 4'h4;
    sw_data_i = 4'h3;
    push(1, 4'h4, 4'h3);
    btn_wr_i = 1;
    repeat (14) tick();
    chk("t5_rel_busy", busy_o, 1);
    chk("t5_wr_seen", q.size(), 0);
    rst_i = 1;
    #1;
    chk_zero("t5_rst_rel");
    model_reset();
    btn_wr_i = 0;
    tick();
    rst_i = 0;
    repeat (20) tick();
    chk("t5_quiet2", busy_o, 0);
`ifdef AUTOINC_EN
    // 6: auto-increment address over 17 reads, wrapping to 0
    for (int i = 0; i < 17; i++) op(0, 4'($urandom_range(0, 15)), 4'h0);
`else
    // 6: address/data latched only at the latch point
    op(1, 4'hE, 4'h1);
    sw_addr_i = 4'h0;
    sw_data_i = 4'h8;
    repeat (3) tick();
    chk("t6_hold_addr", addr_o, 4'hE);
    chk("t6_hold_data", dato_write_o, 4'h1);
    for (int i = 0; i < 4; i++) op(0, 4'(i * 5 + 1), 4'(i + 7));
    op(1, 4'hF, 4'h0);
    op(0, 4'h0, 4'h5);
`endif
    chk("end_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
